// File: rtl/psk_sym_sched.sv
// psk_sym_sched
// Symbol-rate scheduler for the PSK transmit path. One clock-enable line of
// the 32.768 MHz divider is latched per frame as the symbol tick; each frame
// runs preamble, payload and guard, pulling payload dibits from an upstream
// valid/ready source and driving the modulator strobe, dibit and enable.
//
// Ports
//   clk32M768  system clock (only clock)
//   rst_n      asynchronous active-low reset
//   ce_vec     divider enables, bit k pulses once every 2^(k+1) cycles
//   rate_sel   tick index into ce_vec, 15 clamps to 14 (latched at start)
//   frame_len  payload symbol count, 0 = no payload (latched at start)
//   start      frame request, honoured only in IDLE
//   abort      synchronous frame abort
//   src_valid  upstream dibit valid
//   src_data   upstream dibit
//   src_ready  combinational consume strobe (payload tick)
//   sym_stb    registered one-cycle symbol strobe
//   tx_data    registered symbol dibit
//   tx_en      registered modulator enable
//   busy       high whenever the FSM is not IDLE
//   done       registered one-cycle end-of-frame pulse
//   underrun   registered one-cycle pulse for an empty payload slot
//
// state | meaning
// IDLE  | waiting for start
// ARM   | waiting for first tick to align to the divider phase, no symbol
// PRE   | preamble, alternating 00/11 starting with 00
// PAY   | payload, one dibit consumed (or underrun) per tick
// GUARD | guard symbols with tx_en low, done on the last one

module psk_sym_sched #(
   parameter int unsigned PRE_LEN   = 32,
   parameter int unsigned GUARD_LEN = 8,
   parameter int unsigned LEN_W     = 12
) (
   input  logic             clk32M768,
   input  logic             rst_n,
   input  logic [14:0]      ce_vec,
   input  logic [3:0]       rate_sel,
   input  logic [LEN_W-1:0] frame_len,
   input  logic             start,
   input  logic             abort,
   input  logic             src_valid,
   input  logic [1:0]       src_data,
   output logic             src_ready,
   output logic             sym_stb,
   output logic [1:0]       tx_data,
   output logic             tx_en,
   output logic             busy,
   output logic             done,
   output logic             underrun
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARM   = 3'd1;
   localparam logic [2:0] S_PRE   = 3'd2;
   localparam logic [2:0] S_PAY   = 3'd3;
   localparam logic [2:0] S_GUARD = 3'd4;

   localparam logic [LEN_W-1:0] PRE_LAST   = LEN_W'(PRE_LEN - 1);
   localparam logic [LEN_W-1:0] GUARD_LAST = LEN_W'(GUARD_LEN - 1);

   logic [2:0]       state_q, state_d;
   logic [3:0]       rate_q, rate_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             sym_stb_q, sym_stb_d;
   logic [1:0]       tx_data_q, tx_data_d;
   logic             tx_en_q, tx_en_d;
   logic             done_q, done_d;
   logic             underrun_q, underrun_d;
   logic             tick;

   // rate_q is clamped at latch time, so it never indexes past bit 14
   assign tick      = ce_vec[rate_q];
   // abort wins over a coincident payload tick, so nothing is consumed then
   assign src_ready = (state_q == S_PAY) & tick & ~abort;

   assign sym_stb  = sym_stb_q;
   assign tx_data  = tx_data_q;
   assign tx_en    = tx_en_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign underrun = underrun_q;

   always_comb begin
      state_d    = state_q;
      rate_d     = rate_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      sym_stb_d  = 1'b0;
      tx_data_d  = tx_data_q;
      tx_en_d    = tx_en_q;
      done_d     = 1'b0;
      underrun_d = 1'b0;

      if (abort && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         cnt_d     = '0;
         tx_data_d = 2'b00;
         tx_en_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  rate_d  = (rate_sel == 4'd15) ? 4'd14 : rate_sel;
                  len_d   = frame_len;
                  cnt_d   = '0;
                  state_d = S_ARM;
               end
            end
            S_ARM: begin
               if (tick) begin
                  cnt_d   = '0;
                  state_d = S_PRE;
               end
            end
            S_PRE: begin
               if (tick) begin
                  sym_stb_d = 1'b1;
                  tx_en_d   = 1'b1;
                  tx_data_d = cnt_q[0] ? 2'b11 : 2'b00;
                  if (cnt_q == PRE_LAST) begin
                     cnt_d   = '0;
                     state_d = (len_q == '0) ? S_GUARD : S_PAY;
                  end else begin
                     cnt_d = cnt_q + LEN_W'(1);
                  end
               end
            end
            S_PAY: begin
               if (tick) begin
                  sym_stb_d  = 1'b1;
                  tx_en_d    = 1'b1;
                  tx_data_d  = src_valid ? src_data : 2'b00;
                  // an empty slot still counts so frame duration stays fixed
                  underrun_d = ~src_valid;
                  if (cnt_q == len_q - LEN_W'(1)) begin
                     cnt_d   = '0;
                     state_d = S_GUARD;
                  end else begin
                     cnt_d = cnt_q + LEN_W'(1);
                  end
               end
            end
            S_GUARD: begin
               if (tick) begin
                  sym_stb_d = 1'b1;
                  tx_en_d   = 1'b0;
                  tx_data_d = 2'b00;
                  if (cnt_q == GUARD_LAST) begin
                     cnt_d   = '0;
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     cnt_d = cnt_q + LEN_W'(1);
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk32M768 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rate_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         sym_stb_q  <= 1'b0;
         tx_data_q  <= 2'b00;
         tx_en_q    <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rate_q     <= rate_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         sym_stb_q  <= sym_stb_d;
         tx_data_q  <= tx_data_d;
         tx_en_q    <= tx_en_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
      end
   end

endmodule
